// File: rtl/mdu_alu_control.sv
// ALU control decoder plus an iterative multiply/divide unit with HI/LO registers.
// Multiply is shift-add, divide is restoring; one step per cycle, WIDTH steps.
module mdu_alu_control #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              valid,
    input  logic [WIDTH-1:0]  rs_val,
    input  logic [WIDTH-1:0]  rt_val,
    output logic [CTRL_W-1:0] alu_control,
    output logic              stall,
    output logic              busy,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output logic [WIDTH-1:0]  mf_data,
    output logic              mf_valid
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 is_r, is_mdu, is_div, signed_op, start, last;
    logic                 rs_neg, rt_neg;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, mul_res;
    logic [WIDTH:0]       div_trial, div_rem;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;

    assign is_r      = (alu_op == 2'b10);
    assign is_mdu    = (funct[5:2] == 4'b0110);
    assign is_div    = funct[1];
    assign signed_op = ~funct[0];
    assign start     = valid & is_r & is_mdu & (state_q == IDLE);
    assign last      = (cnt_q == CW'(WIDTH - 1));

    assign rs_neg = signed_op & rs_val[WIDTH-1];
    assign rt_neg = signed_op & rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? -rs_val : rs_val;
    assign rt_mag = rt_neg ? -rt_val : rt_val;

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_res  = neg_lo_q ? -mul_next : mul_next;

    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, opb_q});
    assign div_rem   = div_ge ? (div_trial - {1'b0, opb_q}) : div_trial;
    assign div_next  = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    acc_d = {{WIDTH{1'b0}}, rs_mag};
                    opb_d = rt_mag;
                    if (is_div) begin
                        // a zero divisor leaves the quotient magnitude all ones; keep it unsigned
                        neg_lo_d = (rs_neg ^ rt_neg) & (rt_val != '0);
                        neg_hi_d = rs_neg;
                        state_d  = DIV;
                    end else begin
                        neg_lo_d = rs_neg ^ rt_neg;
                        neg_hi_d = rs_neg ^ rt_neg;
                        state_d  = MUL;
                    end
                end else if (valid && is_r && funct == F_MTHI) begin
                    hi_d = rs_val;
                end else if (valid && is_r && funct == F_MTLO) begin
                    lo_d = rs_val;
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    hi_d    = mul_res[2*WIDTH-1:WIDTH];
                    lo_d    = mul_res[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    hi_d    = neg_hi_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
                    lo_d    = neg_lo_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        alu_control = '0;
        case (alu_op)
            2'b00: alu_control = CTRL_W'(4'b0010);
            2'b01: alu_control = CTRL_W'(4'b0110);
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: alu_control = CTRL_W'(4'b0010);
                    6'b100010, 6'b100011: alu_control = CTRL_W'(4'b0110);
                    6'b100100:            alu_control = CTRL_W'(4'b0000);
                    6'b100101:            alu_control = CTRL_W'(4'b0001);
                    6'b100111:            alu_control = CTRL_W'(4'b1100);
                    6'b101010:            alu_control = CTRL_W'(4'b0111);
                    default:              alu_control = '0;
                endcase
            end
            default: alu_control = '0;
        endcase
    end

    always_comb begin
        mf_data = '0;
        if (is_r && funct == F_MFHI) begin
            mf_data = hi_q;
        end else if (is_r && funct == F_MFLO) begin
            mf_data = lo_q;
        end
    end

    assign mf_valid = valid & is_r & ((funct == F_MFHI) | (funct == F_MFLO));
    assign busy     = (state_q == MUL) | (state_q == DIV);
    assign stall    = start | busy;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_alu_control.sv
// Bench for mdu_alu_control: decode table, directed MDU table, randomized MDU ops
// against an arithmetic reference model, and reset/mthi/mfhi sequences.
module tb_mdu_alu_control;

    localparam int W = 32;

    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic         valid;
    logic [W-1:0] rs_val, rt_val;
    logic [3:0]   alu_control;
    logic         stall, busy, mf_valid;
    logic [W-1:0] hi, lo, mf_data;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_alu_control #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct), .valid(valid),
        .rs_val(rs_val), .rt_val(rt_val), .alu_control(alu_control), .stall(stall),
        .busy(busy), .hi(hi), .lo(lo), .mf_data(mf_data), .mf_valid(mf_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] ua, ub;
        sa = a;
        sb = b;
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            MULT: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            MULTU: return ua * ub;
            DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
    endfunction

    task automatic run_mdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int n;
        @(negedge clk);
        valid = 1'b1; alu_op = 2'b10; funct = f; rs_val = a; rt_val = b;
        #1;
        chk("start_stall", 64'(stall), 64'(1));
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            rs_val = $urandom;
            rt_val = $urandom;
            #1;
        end
        chk("stall_cycles", 64'(n), 64'(W + 1));
        chk("done_busy", 64'(busy), 64'(0));
        chk("hi", 64'(hi), 64'(exp_hi));
        chk("lo", 64'(lo), 64'(exp_lo));
        // mtlo arriving in DONE must be ignored, and no restart may occur
        funct = MTLO; rs_val = 32'hDEAD_BEEF;
        #1;
        chk("done_no_restart", 64'(stall), 64'(0));
        @(negedge clk);
        funct = MFHI;
        #1;
        chk("lo_after_done_mtlo", 64'(lo), 64'(exp_lo));
        chk("mfhi_data", 64'(mf_data), 64'(exp_hi));
        chk("mfhi_valid", 64'(mf_valid), 64'(1));
        @(negedge clk);
        funct = MFLO;
        #1;
        chk("mflo_data", 64'(mf_data), 64'(exp_lo));
        @(negedge clk);
        valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] exp_ctrl;
        logic       exp_mfv;
    } dec_vec_t;

    typedef struct {
        logic [5:0]   f;
        logic [W-1:0] a, b, exp_hi, exp_lo;
    } mdu_vec_t;

    dec_vec_t dec_tbl[$];
    mdu_vec_t mdu_tbl[$];

    initial begin
        dec_tbl = '{
            '{2'b00, 6'b101010, 4'b0010, 1'b0},
            '{2'b01, 6'b100000, 4'b0110, 1'b0},
            '{2'b11, 6'b100101, 4'b0000, 1'b0},
            '{2'b10, 6'b100000, 4'b0010, 1'b0},
            '{2'b10, 6'b100001, 4'b0010, 1'b0},
            '{2'b10, 6'b100010, 4'b0110, 1'b0},
            '{2'b10, 6'b100011, 4'b0110, 1'b0},
            '{2'b10, 6'b100100, 4'b0000, 1'b0},
            '{2'b10, 6'b100101, 4'b0001, 1'b0},
            '{2'b10, 6'b100111, 4'b1100, 1'b0},
            '{2'b10, 6'b101010, 4'b0111, 1'b0},
            '{2'b10, 6'b000000, 4'b0000, 1'b0},
            '{2'b10, 6'b010000, 4'b0000, 1'b1},
            '{2'b10, 6'b010010, 4'b0000, 1'b1}
        };
        mdu_tbl = '{
            '{MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB},
            '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14},
            '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD},
            '{DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF},
            '{DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF},
            '{DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF},
            '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000},
            '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD},
            '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
            '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}
        };

        reset = 1'b1; valid = 1'b1; alu_op = 2'b10; funct = MTHI;
        rs_val = 32'h0000_AAAA; rt_val = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        reset = 1'b0; valid = 1'b0;

        foreach (dec_tbl[i]) begin
            @(negedge clk);
            valid = 1'b1; alu_op = dec_tbl[i].op; funct = dec_tbl[i].f;
            #1;
            chk($sformatf("dec_ctrl[%0d]", i), 64'(alu_control), 64'(dec_tbl[i].exp_ctrl));
            chk($sformatf("dec_stall[%0d]", i), 64'(stall), 64'(0));
            chk($sformatf("dec_mfv[%0d]", i), 64'(mf_valid), 64'(dec_tbl[i].exp_mfv));
            if (!dec_tbl[i].exp_mfv) chk($sformatf("dec_mfdata[%0d]", i), 64'(mf_data), 64'(0));
        end
        @(negedge clk);
        valid = 1'b0;

        foreach (mdu_tbl[i])
            run_mdu(mdu_tbl[i].f, mdu_tbl[i].a, mdu_tbl[i].b, mdu_tbl[i].exp_hi, mdu_tbl[i].exp_lo);

        for (int k = 0; k < 20; k++) begin
            logic [5:0]   f;
            logic [W-1:0] a, b;
            logic [63:0]  r;
            case ($urandom_range(0, 3))
                0: f = MULT;
                1: f = MULTU;
                2: f = DIV;
                default: f = DIVU;
            endcase
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin b = '1; a = 32'h8000_0000; end
                2: b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            r = model(f, a, b);
            run_mdu(f, a, b, r[63:32], r[31:0]);
        end

        @(negedge clk);
        valid = 1'b1; alu_op = 2'b10; funct = MULT; rs_val = 32'hFFFF_FFFD; rt_val = 32'd7;
        repeat (10) @(negedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'(1));
        reset = 1'b1; valid = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_stall", 64'(stall), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        valid = 1'b1; alu_op = 2'b10; funct = MTHI; rs_val = 32'h0000_1234;
        @(negedge clk);
        funct = MFHI; rs_val = '0;
        #1;
        chk("mthi_mfhi_data", 64'(mf_data), 64'h1234);
        chk("mthi_mfhi_valid", 64'(mf_valid), 64'(1));
        chk("mthi_lo_kept", 64'(lo), 64'(0));
        @(negedge clk);
        valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
